// File: rtl/pwm_pkg.sv
// Shared types and defaults for the multi-channel PWM generator.
package pwm_pkg;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    localparam int unsigned DefChannels  = 4;
    localparam int unsigned DefWidth     = 8;
    localparam int unsigned DefPrescaleW = 8;

    function automatic int unsigned ch_idx_w(input int unsigned channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/pwm_multi_ch_if.sv
// Duty shadow-register write port: the config decoder drives it, the PWM block consumes it.
interface pwm_multi_ch_if
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned CH_W  = ch_idx_w(DefChannels)
);
    logic             wr_en;
    logic [CH_W-1:0]  wr_ch;
    logic [WIDTH-1:0] wr_duty;

    modport master (output wr_en, wr_ch, wr_duty);
    modport slave  (input  wr_en, wr_ch, wr_duty);
endinterface

// File: rtl/pwm_timebase.sv
// Prescaler plus edge/center-aligned counter; period and mode are latched only at boundaries.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH      = DefWidth,
    parameter int unsigned PRESCALE_W = DefPrescaleW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [WIDTH-1:0]      period,
    input  logic                  center_mode,
    output logic [WIDTH-1:0]      cnt,
    output logic                  tick,
    output logic                  boundary
);
    localparam logic [WIDTH-1:0]      CntOne   = 1;
    localparam logic [PRESCALE_W-1:0] PrescOne = 1;

    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [WIDTH-1:0]      cnt_q, cnt_d, period_q, period_d, cnt_step;
    pwm_mode_e             mode_q, mode_d;
    logic                  down_q, down_d, going_down;

    always_comb begin
        tick       = en && (presc_q == prescale);
        going_down = down_q ? (cnt_q != '0) : (cnt_q >= period_q);
        if (period_q == '0) begin
            cnt_step = '0;
        end else if (mode_q == PWM_CENTER) begin
            cnt_step = going_down ? cnt_q - CntOne : cnt_q + CntOne;
        end else begin
            cnt_step = (cnt_q >= period_q) ? '0 : cnt_q + CntOne;
        end
        // Any step that lands on 0 from a nonzero count closes a period (P->0 or 1->0).
        boundary = tick && ((period_q == '0) || ((cnt_q != '0) && (cnt_step == '0)));

        presc_d  = presc_q;
        cnt_d    = cnt_q;
        down_d   = down_q;
        period_d = period_q;
        mode_d   = mode_q;
        if (!en) begin
            presc_d  = '0;
            cnt_d    = '0;
            down_d   = 1'b0;
            period_d = period;
            mode_d   = pwm_mode_e'(center_mode);
        end else begin
            presc_d = tick ? '0 : presc_q + PrescOne;
            if (tick) begin
                cnt_d  = cnt_step;
                down_d = (mode_q == PWM_CENTER) && going_down && (cnt_step != '0);
            end
            if (boundary) begin
                period_d = period;
                mode_d   = pwm_mode_e'(center_mode);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q  <= '0;
            cnt_q    <= '0;
            down_q   <= 1'b0;
            period_q <= '1;
            mode_q   <= PWM_EDGE;
        end else begin
            presc_q  <= presc_d;
            cnt_q    <= cnt_d;
            down_q   <= down_d;
            period_q <= period_d;
            mode_q   <= mode_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM: double-buffered duty per channel, shared timebase, registered outputs.
module pwm_multi_ch
    import pwm_pkg::*;
#(
    parameter int unsigned CHANNELS   = DefChannels,
    parameter int unsigned WIDTH      = DefWidth,
    parameter int unsigned PRESCALE_W = DefPrescaleW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [WIDTH-1:0]      period,
    input  logic                  center_mode,
    pwm_multi_ch_if.slave         wr_bus,
    output logic [CHANNELS-1:0]   pwm_out,
    output logic                  period_end
);
    logic [WIDTH-1:0]    cnt;
    logic                tick, boundary;
    logic [WIDTH-1:0]    shadow_q [CHANNELS];
    logic [WIDTH-1:0]    shadow_d [CHANNELS];
    logic [WIDTH-1:0]    active_q [CHANNELS];
    logic [WIDTH-1:0]    active_d [CHANNELS];
    logic [CHANNELS-1:0] pwm_q, pwm_d;
    logic                bnd_q, bnd_d, period_end_q, period_end_d;

    pwm_timebase #(
        .WIDTH      (WIDTH),
        .PRESCALE_W (PRESCALE_W)
    ) u_timebase (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .prescale    (prescale),
        .period      (period),
        .center_mode (center_mode),
        .cnt         (cnt),
        .tick        (tick),
        .boundary    (boundary)
    );

    // Active copies read the pre-write shadow, so a write landing on a boundary waits one period.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (wr_bus.wr_en && (int'(wr_bus.wr_ch) == i)) begin
                shadow_d[i] = wr_bus.wr_duty;
            end
            if (!en || (tick && boundary)) begin
                active_d[i] = shadow_q[i];
            end
        end
        // Two stages so period_end lines up with the pwm_out sample of count 0.
        bnd_d        = en && boundary;
        period_end_d = en && bnd_q;
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        assign pwm_d[g] = en && (cnt < active_q[g]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q     <= '{default: '0};
            active_q     <= '{default: '0};
            pwm_q        <= '0;
            bnd_q        <= 1'b0;
            period_end_q <= 1'b0;
        end else begin
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            pwm_q        <= pwm_d;
            bnd_q        <= bnd_d;
            period_end_q <= period_end_d;
        end
    end

    assign pwm_out    = pwm_q;
    assign period_end = period_end_q;

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Directed bench for pwm_multi_ch: vector table of configurations plus hand-written corner sequences.
module tb_pwm_multi_ch;
    localparam int unsigned CH = 4;
    localparam int unsigned W  = 8;
    localparam int unsigned PW = 8;

    logic          clk = 1'b0;
    logic          rst, en, center_mode;
    logic [PW-1:0] prescale;
    logic [W-1:0]  period;
    logic [CH-1:0] pwm_out;
    logic          period_end;

    int checks = 0;
    int errors = 0;

    pwm_multi_ch_if #(.WIDTH(W), .CH_W(2)) bus ();

    pwm_multi_ch #(
        .CHANNELS   (CH),
        .WIDTH      (W),
        .PRESCALE_W (PW)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .prescale    (prescale),
        .period      (period),
        .center_mode (center_mode),
        .wr_bus      (bus),
        .pwm_out     (pwm_out),
        .period_end  (period_end)
    );

    always #5 clk = ~clk;

    typedef struct {
        int psc; int per; int ctr;
        int d0; int d1; int d2; int d3;
        int len;
        int h0; int h1; int h2; int h3;
    } vec_t;

    vec_t vecs [7];

    function automatic vec_t mk(int psc, int per, int ctr, int d0, int d1, int d2, int d3,
                                int len, int h0, int h1, int h2, int h3);
        vec_t v;
        v.psc = psc; v.per = per; v.ctr = ctr;
        v.d0 = d0; v.d1 = d1; v.d2 = d2; v.d3 = d3;
        v.len = len;
        v.h0 = h0; v.h1 = h1; v.h2 = h2; v.h3 = h3;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input int d);
        bus.wr_en   = 1'b1;
        bus.wr_ch   = ch[1:0];
        bus.wr_duty = d[W-1:0];
        step();
        bus.wr_en   = 1'b0;
    endtask

    task automatic configure(input int psc, input int per, input int ctr,
                             input int d0, input int d1, input int d2, input int d3);
        en = 1'b0;
        step();
        step();
        wr(0, d0);
        wr(1, d1);
        wr(2, d2);
        wr(3, d3);
        prescale    = psc[PW-1:0];
        period      = per[W-1:0];
        center_mode = ctr[0];
        step();
        en = 1'b1;
    endtask

    task automatic wait_pe(input string name, output bit ok);
        int n = 0;
        while (!period_end && n < 2000) begin
            step();
            n++;
        end
        ok = period_end;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s: period_end timeout, got 0, expected 1", name);
        end
    endtask

    initial begin
        bit ok;
        int len, pe_cnt, pat;
        int hi [4];

        rst = 1'b1; en = 1'b1; prescale = '0; period = 8'd9; center_mode = 1'b0;
        bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_duty = '0;
        step(); step(); step();
        check("reset_pwm_out", int'(pwm_out), 0);
        check("reset_period_end", int'(period_end), 0);
        check("reset_active_period", int'(u_dut.u_timebase.period_q), 255);
        rst = 1'b0;
        en  = 1'b0;

        vecs[0] = mk(0,   9, 0,   3,   0, 10,   9,  10,   3,   0, 10,  9);
        vecs[1] = mk(0,   4, 1,   2,   0,  5,   4,   8,   3,   0,  8,  7);
        vecs[2] = mk(3,   9, 0,   5,   1,  9, 255,  40,  20,   4, 36, 40);
        vecs[3] = mk(1,   3, 1,   1,   2,  3,   4,  12,   2,   6, 10, 12);
        vecs[4] = mk(0,   0, 0,   0,   1,  1,   0,   1,   0,   1,  1,  0);
        vecs[5] = mk(2,   0, 1,   1,   0,  2,   0,   3,   3,   0,  3,  0);
        vecs[6] = mk(0, 255, 0, 255, 128,  0,   1, 256, 255, 128,  0,  1);

        for (int v = 0; v < 7; v++) begin
            configure(vecs[v].psc, vecs[v].per, vecs[v].ctr,
                      vecs[v].d0, vecs[v].d1, vecs[v].d2, vecs[v].d3);
            wait_pe($sformatf("vec%0d", v), ok);
            if (ok) begin
                len = 0;
                for (int c = 0; c < 4; c++) hi[c] = 0;
                do begin
                    for (int c = 0; c < 4; c++) hi[c] += int'(pwm_out[c]);
                    len++;
                    step();
                end while (!period_end && len < 5000);
                check($sformatf("vec%0d_len", v), len, vecs[v].len);
                check($sformatf("vec%0d_hi0", v), hi[0], vecs[v].h0);
                check($sformatf("vec%0d_hi1", v), hi[1], vecs[v].h1);
                check($sformatf("vec%0d_hi2", v), hi[2], vecs[v].h2);
                check($sformatf("vec%0d_hi3", v), hi[3], vecs[v].h3);
            end
        end

        // Center-aligned pulse straddles period_end: high for counts 1,0,1.
        configure(0, 4, 1, 2, 0, 0, 0);
        wait_pe("center_win", ok);
        if (ok) begin
            pat = 0;
            for (int c = 0; c < 8; c++) begin
                pat |= int'(pwm_out[0]) << c;
                step();
            end
            check("center_window", pat, 'h83);
            check("center_pe_next", int'(period_end), 1);
        end

        // Mid-period write (3->7) and a write coinciding with the boundary tick (->5).
        configure(0, 9, 0, 3, 0, 0, 0);
        wait_pe("shadow", ok);
        if (ok) begin
            pe_cnt = 0;
            for (int c = 0; c < 4; c++) hi[c] = 0;
            for (int c = 0; c < 30; c++) begin
                hi[c / 10] += int'(pwm_out[0]);
                pe_cnt += int'(period_end);
                bus.wr_ch = '0;
                if (c == 1) begin
                    bus.wr_en = 1'b1; bus.wr_duty = 8'd7;
                end else if (c == 8) begin
                    bus.wr_en = 1'b1; bus.wr_duty = 8'd5;
                end else begin
                    bus.wr_en = 1'b0;
                end
                step();
            end
            bus.wr_en = 1'b0;
            check("shadow_p0_old", hi[0], 3);
            check("shadow_p1_mid_write", hi[1], 7);
            check("shadow_p2_bnd_write", hi[2], 5);
            check("shadow_pe_count", pe_cnt, 3);
        end

        // Reset mid-period with all outputs high.
        configure(0, 9, 0, 7, 7, 7, 7);
        wait_pe("reset_mid", ok);
        if (ok) begin
            for (int c = 0; c < 4; c++) step();
            check("pre_reset_high", int'(pwm_out), 'hf);
            rst = 1'b1;
            step();
            rst = 1'b0;
            check("mid_reset_pwm", int'(pwm_out), 0);
            check("mid_reset_cnt", int'(u_dut.u_timebase.cnt_q), 0);
            check("mid_reset_duty", int'(u_dut.active_q[0]), 0);
            len = 0;
            for (int c = 0; c < 20; c++) begin
                len += int'(pwm_out != '0);
                step();
            end
            check("post_reset_low", len, 0);
        end

        // Drop en mid-period, write while idle, re-enable restarts from cnt 0.
        configure(0, 9, 0, 5, 0, 0, 0);
        wait_pe("en_drop", ok);
        if (ok) begin
            for (int c = 0; c < 3; c++) step();
            en = 1'b0;
            step();
            check("en_drop_pwm", int'(pwm_out), 0);
            check("en_drop_pe", int'(period_end), 0);
            wr(0, 2);
            step();
            en = 1'b1;
            hi[0] = 0;
            pe_cnt = 0;
            for (int j = 1; j <= 10; j++) begin
                step();
                if (j == 1) check("reen_first_high", int'(pwm_out[0]), 1);
                hi[0] += int'(pwm_out[0]);
                pe_cnt += int'(period_end);
            end
            step();
            check("reen_hi", hi[0], 2);
            check("reen_no_early_pe", pe_cnt, 0);
            check("reen_pe_at_11", int'(period_end), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
